// File: rtl/send_top_link.sv
// send_top_link: ADC word -> six byte slots or test pattern -> 8b/10b symbols, plus clk/6 frame clock.
// Slot chosen at edge E is on encoder_out after E+1; free-running, one symbol per clock, no backpressure.
module send_top_link #(
    parameter int         WORD_W    = 48,
    parameter logic [3:0] LFSR_SEED = 4'b0001
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] data_i,
    input  logic              sync,
    input  logic              mod,
    input  logic [1:0]        i_test_patten,
    input  logic [2:0]        out_select,
    output logic [9:0]        encoder_out,
    output logic              RD_out,
    output logic [3:0]        lfrs_out,
    output logic [2:0]        data_ctrl,
    output logic              clk_new
);
    localparam logic [7:0] K28_5 = 8'hBC;
    // 5b/6b codes (abcdei) for RD-; RD+ is the complement for unbalanced codes and D.7
    localparam logic [5:0] C6 [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};

    logic [2:0]        r_cnt, r_cnt_d, r_idx, r_ctrl;
    logic [WORD_W-1:0] r_word;
    logic [7:0]        r_byte, r_pcnt;
    logic              r_k, r_flag, r_rd, r_clk;
    logic [3:0]        r_lfsr;
    logic [9:0]        r_enc;

    logic [WORD_W-1:0] w_word;
    logic [7:0]        w_pat, w_byte;
    logic [2:0]        w_idx;
    logic              w_k, w_adv;
    logic [4:0]        w_x;
    logic [2:0]        w_y;
    logic [5:0]        w_c6, w_d6;
    logic [3:0]        w_c4, w_d4;
    logic              w_rd6, w_rd_nxt, w_a7;
    logic [9:0]        w_sym;

    function automatic logic [7:0] pick(input logic [WORD_W-1:0] w, input logic [2:0] k);
        case (k)
            3'd0:    pick = w[47:40];
            3'd1:    pick = w[39:32];
            3'd2:    pick = w[31:24];
            3'd3:    pick = w[23:16];
            3'd4:    pick = w[15:8];
            default: pick = w[7:0];
        endcase
    endfunction

    // Slot selection: slot 0 takes the byte straight from data_i since the word loads on this edge
    always_comb begin
        w_word = (r_cnt == 3'd0) ? data_i : r_word;
        case (i_test_patten)
            2'b00:   w_pat = 8'hB5;
            2'b01:   w_pat = r_flag ? 8'h55 : 8'hAA;
            2'b10:   w_pat = r_pcnt;
            default: w_pat = {r_lfsr, ~r_lfsr};
        endcase
        w_byte = K28_5;
        w_idx  = 3'd7;
        w_k    = 1'b1;
        w_adv  = 1'b0;
        if (sync && out_select != 3'd7) begin
            w_k = 1'b0;
            if (mod) begin
                w_byte = w_pat;
                w_idx  = r_cnt;
                w_adv  = 1'b1;
            end else if (out_select == 3'd0) begin
                w_byte = pick(w_word, r_cnt);
                w_idx  = r_cnt;
            end else begin
                w_byte = pick(w_word, out_select - 3'd1);
                w_idx  = out_select - 3'd1;
            end
        end
    end

    // 8b/10b: the 3b/4b choice and the A7 alternate depend on disparity after the 6b sub-block
    always_comb begin
        w_x   = r_byte[4:0];
        w_y   = r_byte[7:5];
        w_c6  = C6[w_x];
        w_d6  = (r_rd && ($countones(w_c6) != 3 || w_x == 5'd7)) ? ~w_c6 : w_c6;
        w_rd6 = ($countones(w_c6) != 3) ? ~r_rd : r_rd;
        w_a7  = w_rd6 ? (w_x == 5'd11 || w_x == 5'd13 || w_x == 5'd14)
                      : (w_x == 5'd17 || w_x == 5'd18 || w_x == 5'd20);
        case (w_y)
            3'd0:    w_c4 = 4'b1011;
            3'd1:    w_c4 = 4'b1001;
            3'd2:    w_c4 = 4'b0101;
            3'd3:    w_c4 = 4'b1100;
            3'd4:    w_c4 = 4'b1101;
            3'd5:    w_c4 = 4'b1010;
            3'd6:    w_c4 = 4'b0110;
            default: w_c4 = w_a7 ? 4'b0111 : 4'b1110;
        endcase
        w_d4     = (w_rd6 && ($countones(w_c4) != 2 || w_y == 3'd3)) ? ~w_c4 : w_c4;
        w_rd_nxt = ($countones(w_c4) != 2) ? ~w_rd6 : w_rd6;
        w_sym    = {w_d6, w_d4};
        if (r_k) begin
            w_sym    = r_rd ? 10'b1100000101 : 10'b0011111010;
            w_rd_nxt = ~r_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 3'd0;
            r_cnt_d <= 3'd7;
            r_word  <= '0;
            r_byte  <= 8'h00;
            r_idx   <= 3'd0;
            r_k     <= 1'b0;
            r_enc   <= 10'd0;
            r_rd    <= 1'b0;
            r_ctrl  <= 3'd0;
            r_clk   <= 1'b0;
            r_lfsr  <= LFSR_SEED;
            r_pcnt  <= 8'h00;
            r_flag  <= 1'b0;
        end else begin
            r_byte <= w_byte;
            r_idx  <= w_idx;
            r_k    <= w_k;
            r_enc  <= w_sym;
            r_rd   <= w_rd_nxt;
            r_ctrl <= r_idx;
            r_clk  <= sync && (r_cnt_d < 3'd3);
            if (!sync) begin
                r_cnt   <= 3'd0;
                r_cnt_d <= 3'd7;
                r_lfsr  <= LFSR_SEED;
                r_pcnt  <= 8'h00;
                r_flag  <= 1'b0;
            end else begin
                r_cnt   <= (r_cnt == 3'd5) ? 3'd0 : r_cnt + 3'd1;
                r_cnt_d <= r_cnt;
                if (r_cnt == 3'd0) r_word <= data_i;
                if (w_adv) begin
                    case (i_test_patten)
                        2'b01:   r_flag <= ~r_flag;
                        2'b10:   r_pcnt <= r_pcnt + 8'd1;
                        2'b11:   r_lfsr <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
                        default: ;
                    endcase
                end
            end
        end
    end

    assign encoder_out = r_enc;
    assign RD_out      = r_rd;
    assign lfrs_out    = r_lfsr;
    assign data_ctrl   = r_ctrl;
    assign clk_new     = r_clk;
endmodule

// File: tb/tb_send_top_link.sv
// Bench for send_top_link: slot-level reference model with explicit RD-/RD+ 8b/10b tables.
module tb_send_top_link;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] data_i;
    logic        sync, mod;
    logic [1:0]  tp;
    logic [2:0]  osel;
    logic [9:0]  encoder_out;
    logic        RD_out;
    logic [3:0]  lfrs_out;
    logic [2:0]  data_ctrl;
    logic        clk_new;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    send_top_link #(.WORD_W(48), .LFSR_SEED(4'b0001)) dut (
        .clk(clk), .rst_n(rst_n), .data_i(data_i), .sync(sync), .mod(mod),
        .i_test_patten(tp), .out_select(osel), .encoder_out(encoder_out),
        .RD_out(RD_out), .lfrs_out(lfrs_out), .data_ctrl(data_ctrl), .clk_new(clk_new)
    );

    logic [5:0] t6n [32];
    logic [5:0] t6p [32];
    logic [3:0] t4n [8];
    logic [3:0] t4p [8];
    logic [3:0] lseq [15];

    // model state: slot counter, held word, pending stage-1 slot, disparity, pattern progress
    int          m_cnt, m_cntd, m_idx, n01, n10, n11;
    logic [47:0] m_word;
    logic [7:0]  m_byte;
    logic        m_k, m_rd;
    logic [9:0]  e_enc;
    logic        e_rd, e_clk;
    logic [2:0]  e_ctrl;
    logic [3:0]  e_lfsr;

    function automatic logic [10:0] enc_ref(input logic [7:0] b, input logic k, input logic rd);
        logic [5:0] s6;
        logic [3:0] s4;
        logic       rd6, rdo;
        int         x, y;
        x = int'(b[4:0]);
        y = int'(b[7:5]);
        if (k) begin
            s6  = rd ? 6'b110000 : 6'b001111;
            rd6 = ~rd;
            s4  = rd6 ? 4'b1010 : 4'b0101;
            rdo = rd6;
        end else begin
            s6  = rd ? t6p[x] : t6n[x];
            rd6 = ($countones(s6) == 3) ? rd : ($countones(s6) > 3);
            if (y == 7 && (rd6 ? (x == 11 || x == 13 || x == 14) : (x == 17 || x == 18 || x == 20)))
                s4 = rd6 ? 4'b1000 : 4'b0111;
            else
                s4 = rd6 ? t4p[y] : t4n[y];
            rdo = ($countones(s4) == 2) ? rd6 : ($countones(s4) > 2);
        end
        return {rdo, s6, s4};
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_cntd = 7; m_idx = 0; n01 = 0; n10 = 0; n11 = 0;
        m_word = '0; m_byte = 8'h00; m_k = 1'b0; m_rd = 1'b0;
        e_enc = 10'd0; e_rd = 1'b0; e_clk = 1'b0; e_ctrl = 3'd0; e_lfsr = lseq[0];
    endtask

    task automatic model_edge();
        logic [10:0] r;
        logic [47:0] w;
        int          bi;
        r      = enc_ref(m_byte, m_k, m_rd);
        e_enc  = r[9:0];
        e_rd   = r[10];
        m_rd   = r[10];
        e_ctrl = 3'(m_idx);
        e_clk  = sync && (m_cntd < 3);
        if (!sync) begin
            m_k = 1'b1; m_byte = 8'hBC; m_idx = 7; m_cntd = 7; m_cnt = 0;
            n01 = 0; n10 = 0; n11 = 0;
        end else begin
            w = (m_cnt == 0) ? data_i : m_word;
            m_cntd = m_cnt;
            m_k = 1'b0;
            if (osel == 3'd7) begin
                m_k = 1'b1; m_byte = 8'hBC; m_idx = 7;
            end else if (mod) begin
                m_idx = m_cnt;
                case (tp)
                    2'd0: m_byte = 8'hB5;
                    2'd1: begin m_byte = (n01 % 2 == 0) ? 8'hAA : 8'h55; n01++; end
                    2'd2: begin m_byte = 8'(n10 % 256); n10++; end
                    default: begin m_byte = {lseq[n11 % 15], ~lseq[n11 % 15]}; n11++; end
                endcase
            end else begin
                bi = (osel == 3'd0) ? m_cnt : int'(osel) - 1;
                m_idx = bi;
                m_byte = w[8*(5-bi) +: 8];
            end
            if (m_cnt == 0) m_word = data_i;
            m_cnt = (m_cnt + 1) % 6;
        end
        e_lfsr = lseq[n11 % 15];
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sync = 1'b0; mod = 1'b0; tp = 2'd0; osel = 3'd0; data_i = '0;
        repeat (2) @(negedge clk);
        checks += 5;
        if (encoder_out !== 10'd0) begin failures++; $display("FAIL reset_enc got=%b exp=%b", encoder_out, 10'd0); end
        if (RD_out !== 1'b0) begin failures++; $display("FAIL reset_rd got=%b exp=0", RD_out); end
        if (data_ctrl !== 3'd0) begin failures++; $display("FAIL reset_ctrl got=%0d exp=0", data_ctrl); end
        if (clk_new !== 1'b0) begin failures++; $display("FAIL reset_clknew got=%b exp=0", clk_new); end
        if (lfrs_out !== 4'b0001) begin failures++; $display("FAIL reset_lfsr got=%b exp=0001", lfrs_out); end
        model_reset();
        rst_n = 1'b1;
        tick();
        checks += 2;
        if (encoder_out !== 10'b1001110100) begin failures++; $display("FAIL post_reset_enc got=%b exp=1001110100", encoder_out); end
        if (encoder_out !== e_enc || RD_out !== e_rd) begin failures++; $display("FAIL post_reset_model got=%b/%b exp=%b/%b", encoder_out, RD_out, e_enc, e_rd); end
    endtask

    task automatic test_sync();
        logic [9:0] kexp [3] = '{10'b0011111010, 10'b1100000101, 10'b0011111010};
        for (int i = 0; i < 3; i++) begin
            tick();
            checks += 3;
            if (encoder_out !== kexp[i]) begin failures++; $display("FAIL sync_k%0d got=%b exp=%b", i, encoder_out, kexp[i]); end
            if (data_ctrl !== 3'd7) begin failures++; $display("FAIL sync_ctrl%0d got=%0d exp=7", i, data_ctrl); end
            if (clk_new !== 1'b0) begin failures++; $display("FAIL sync_clknew%0d got=%b exp=0", i, clk_new); end
        end
        sync = 1'b1;
        data_i = 48'({$urandom(), $urandom()});
        tick();
        checks++;
        if (encoder_out !== 10'b1100000101) begin failures++; $display("FAIL sync_release_k got=%b exp=1100000101", encoder_out); end
        tick();
        checks += 2;
        if (data_ctrl !== 3'd0) begin failures++; $display("FAIL sync_byte0_ctrl got=%0d exp=0", data_ctrl); end
        if (encoder_out !== e_enc || RD_out !== e_rd) begin failures++; $display("FAIL sync_byte0 got=%b/%b exp=%b/%b", encoder_out, RD_out, e_enc, e_rd); end
    endtask

    task automatic test_normal();
        @(negedge clk); rst_n = 1'b0;
        sync = 1'b0; mod = 1'b0; osel = 3'd0; data_i = 48'h0102_0304_0506;
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        tick(); tick();
        sync = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            tick();
            checks += 4;
            if (encoder_out !== e_enc || RD_out !== e_rd) begin failures++; $display("FAIL normal_sym%0d got=%b/%b exp=%b/%b", i, encoder_out, RD_out, e_enc, e_rd); end
            if (data_ctrl !== 3'(i % 6)) begin failures++; $display("FAIL normal_ctrl%0d got=%0d exp=%0d", i, data_ctrl, i % 6); end
            if (clk_new !== ((i % 6) < 3)) begin failures++; $display("FAIL normal_clknew%0d got=%b exp=%b", i, clk_new, (i % 6) < 3); end
            if (clk_new !== e_clk) begin failures++; $display("FAIL normal_clkmodel%0d got=%b exp=%b", i, clk_new, e_clk); end
            if (i == 0) begin
                checks += 2;
                if (encoder_out !== 10'b0111010100) begin failures++; $display("FAIL normal_d1_0 got=%b exp=0111010100", encoder_out); end
                if (RD_out !== 1'b0) begin failures++; $display("FAIL normal_d1_0_rd got=%b exp=0", RD_out); end
            end
        end
    endtask

    task automatic test_byte_select();
        logic prd;
        osel = 3'd3;
        tick();
        for (int i = 0; i < 12; i++) begin
            tick();
            checks += 3;
            if (data_ctrl !== 3'd2) begin failures++; $display("FAIL sel3_ctrl%0d got=%0d exp=2", i, data_ctrl); end
            if (encoder_out !== e_enc || RD_out !== e_rd) begin failures++; $display("FAIL sel3_sym%0d got=%b/%b exp=%b/%b", i, encoder_out, RD_out, e_enc, e_rd); end
            if (clk_new !== e_clk) begin failures++; $display("FAIL sel3_clk%0d got=%b exp=%b", i, clk_new, e_clk); end
        end
        osel = 3'd7;
        tick();
        for (int i = 0; i < 6; i++) begin
            prd = m_rd;
            tick();
            checks += 2;
            if (data_ctrl !== 3'd7) begin failures++; $display("FAIL sel7_ctrl%0d got=%0d exp=7", i, data_ctrl); end
            if (encoder_out !== (prd ? 10'b1100000101 : 10'b0011111010)) begin failures++; $display("FAIL sel7_k%0d got=%b prev_rd=%b", i, encoder_out, prd); end
        end
    endtask

    task automatic test_lfsr();
        logic [3:0] lexp [4] = '{4'b0010, 4'b0100, 4'b1001, 4'b0011};
        mod = 1'b1; tp = 2'd3; osel = 3'd0; sync = 1'b0;
        tick();
        checks++;
        if (lfrs_out !== 4'b0001) begin failures++; $display("FAIL lfsr_seed got=%b exp=0001", lfrs_out); end
        sync = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            checks += 2;
            if (lfrs_out !== e_lfsr) begin failures++; $display("FAIL lfsr_step%0d got=%b exp=%b", i, lfrs_out, e_lfsr); end
            if (encoder_out !== e_enc || RD_out !== e_rd) begin failures++; $display("FAIL lfsr_sym%0d got=%b/%b exp=%b/%b", i, encoder_out, RD_out, e_enc, e_rd); end
            if (i < 4) begin
                checks++;
                if (lfrs_out !== lexp[i]) begin failures++; $display("FAIL lfsr_seq%0d got=%b exp=%b", i, lfrs_out, lexp[i]); end
            end
            if (i == 14) begin
                checks++;
                if (lfrs_out !== 4'b0001) begin failures++; $display("FAIL lfsr_period got=%b exp=0001", lfrs_out); end
            end
        end
    endtask

    task automatic test_patterns();
        logic [1:0] plist [3] = '{2'd1, 2'd2, 2'd0};
        for (int p = 0; p < 3; p++) begin
            tp = plist[p]; mod = 1'b1; osel = 3'd0; sync = 1'b0;
            tick();
            sync = 1'b1;
            for (int i = 0; i < 300; i++) begin
                osel = ($urandom_range(0, 9) < 2) ? 3'd7 : 3'd0;
                tick();
                checks += 3;
                if (encoder_out !== e_enc || RD_out !== e_rd) begin failures++; $display("FAIL pat%0d_sym%0d got=%b/%b exp=%b/%b", tp, i, encoder_out, RD_out, e_enc, e_rd); end
                if (data_ctrl !== e_ctrl) begin failures++; $display("FAIL pat%0d_ctrl%0d got=%0d exp=%0d", tp, i, data_ctrl, e_ctrl); end
                if (lfrs_out !== e_lfsr) begin failures++; $display("FAIL pat%0d_lfsr%0d got=%b exp=%b", tp, i, lfrs_out, e_lfsr); end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            sync = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 5) == 0) begin
                mod  = 1'($urandom_range(0, 1));
                osel = 3'($urandom_range(0, 7));
                tp   = 2'($urandom_range(0, 3));
            end
            data_i = 48'({$urandom(), $urandom()});
            tick();
            checks += 5;
            if (encoder_out !== e_enc) begin failures++; $display("FAIL rnd_enc%0d got=%b exp=%b", i, encoder_out, e_enc); end
            if (RD_out !== e_rd) begin failures++; $display("FAIL rnd_rd%0d got=%b exp=%b", i, RD_out, e_rd); end
            if (data_ctrl !== e_ctrl) begin failures++; $display("FAIL rnd_ctrl%0d got=%0d exp=%0d", i, data_ctrl, e_ctrl); end
            if (clk_new !== e_clk) begin failures++; $display("FAIL rnd_clk%0d got=%b exp=%b", i, clk_new, e_clk); end
            if (lfrs_out !== e_lfsr) begin failures++; $display("FAIL rnd_lfsr%0d got=%b exp=%b", i, lfrs_out, e_lfsr); end
        end
    endtask

    task automatic test_reset_midframe();
        int n = 0;
        sync = 1'b1; mod = 1'b1; tp = 2'd3; osel = 3'd0;
        while (!(e_rd && lfrs_out != 4'b0001) && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (!(RD_out === 1'b1 && e_rd)) begin failures++; $display("FAIL midreset_setup got_rd=%b exp=1", RD_out); end
        #2 rst_n = 1'b0;
        #1;
        checks += 5;
        if (encoder_out !== 10'd0) begin failures++; $display("FAIL midreset_enc got=%b exp=0", encoder_out); end
        if (RD_out !== 1'b0) begin failures++; $display("FAIL midreset_rd got=%b exp=0", RD_out); end
        if (data_ctrl !== 3'd0) begin failures++; $display("FAIL midreset_ctrl got=%0d exp=0", data_ctrl); end
        if (clk_new !== 1'b0) begin failures++; $display("FAIL midreset_clk got=%b exp=0", clk_new); end
        if (lfrs_out !== 4'b0001) begin failures++; $display("FAIL midreset_lfsr got=%b exp=0001", lfrs_out); end
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (encoder_out !== e_enc || RD_out !== e_rd || lfrs_out !== e_lfsr) begin failures++; $display("FAIL midreset_after%0d got=%b/%b/%b exp=%b/%b/%b", i, encoder_out, RD_out, lfrs_out, e_enc, e_rd, e_lfsr); end
        end
    endtask

    initial begin
        t6n = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
                6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
                6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
                6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
        t6p = '{6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
                6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
                6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
                6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
        t4n = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
        t4p = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
        lseq[0] = 4'b0001;
        for (int i = 1; i < 15; i++) lseq[i] = {lseq[i-1][2:0], lseq[i-1][3] ^ lseq[i-1][2]};
        model_reset();
        test_reset();
        test_sync();
        test_normal();
        test_byte_select();
        test_lfsr();
        test_patterns();
        test_random();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
